// File: rtl/tensor_pkg.sv
// Shared tensor-datapath types: systolic core state encoding and the
// accumulator width legality check used at elaboration.
package tensor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_state_t;

  function automatic bit acc_width_ok(input int data_w, input int acc_w, input int rows);
    return acc_w >= (2 * data_w + $clog2(rows));
  endfunction

endpackage

// File: rtl/systolic_array_db_if.sv
// Control, weight-load, activation and result channels of the systolic core.
// The core uses the slave modport; the producer/consumer side uses master.
interface systolic_array_db_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic                         start;
  logic [15:0]                  cfg_m_rows;
  logic                         cfg_signed;
  logic                         busy;
  logic                         done;
  logic                         weight_load_en;
  logic [COL_W-1:0]             weight_load_col;
  logic [ROWS*DATA_WIDTH-1:0]   weight_load_data;
  logic                         act_valid;
  logic [ROWS*DATA_WIDTH-1:0]   act_data;
  logic                         act_ready;
  logic                         result_valid;
  logic [COLS*ACC_WIDTH-1:0]    result_data;
  logic                         result_ready;

  modport slave (
    input  start, cfg_m_rows, cfg_signed, weight_load_en, weight_load_col,
           weight_load_data, act_valid, act_data, result_ready,
    output busy, done, act_ready, result_valid, result_data
  );

  modport master (
    output start, cfg_m_rows, cfg_signed, weight_load_en, weight_load_col,
           weight_load_data, act_valid, act_data, result_ready,
    input  busy, done, act_ready, result_valid, result_data
  );
endinterface

// File: rtl/systolic_pe.sv
// One weight-stationary processing element: forwards the activation to the
// right and adds its product to the partial sum flowing down.
module systolic_pe
  import tensor_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold_i,
  input  logic                  sgn_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [ACC_WIDTH-1:0]  psum_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [ACC_WIDTH-1:0]  psum_o
);
  logic [DATA_WIDTH-1:0] a_q;
  logic [ACC_WIDTH-1:0]  psum_q;
  logic [ACC_WIDTH-1:0]  a_ext_s, w_ext_s, sum_s;

  // Extending both operands to ACC_WIDTH makes the truncated product correct in either mode
  always_comb begin
    a_ext_s = sgn_i ? {{(ACC_WIDTH-DATA_WIDTH){a_i[DATA_WIDTH-1]}}, a_i}
                    : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a_i};
    w_ext_s = sgn_i ? {{(ACC_WIDTH-DATA_WIDTH){w_i[DATA_WIDTH-1]}}, w_i}
                    : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, w_i};
    sum_s   = psum_i + a_ext_s * w_ext_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      psum_q <= '0;
    end else if (!hold_i) begin
      a_q    <= a_i;
      psum_q <= sum_s;
    end
  end

  assign a_o    = a_q;
  assign psum_o = psum_q;
endmodule

// File: rtl/systolic_array_db.sv
// Weight-stationary ROWS x COLS systolic matmul core with shadow/active weight
// banks, input skew, output deskew and whole-pipeline result backpressure.
module systolic_array_db
  import tensor_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_array_db_if.slave   bus
);
  localparam int          LAT    = ROWS + COLS;
  localparam logic [31:0] COLS_U = 32'(COLS);

  if (!acc_width_ok(DATA_WIDTH, ACC_WIDTH, ROWS)) begin : g_width_chk
    $error("ACC_WIDTH too narrow for DATA_WIDTH and ROWS");
  end

  sa_state_t state_q, state_d;
  logic [15:0] m_rows_q, m_rows_d, acc_cnt_q, acc_cnt_d, res_cnt_q, res_cnt_d;
  logic        sgn_q, sgn_d;
  logic        stall_s, act_ready_s, accept_s, res_hs_s, start_acc_s;

  logic [DATA_WIDTH-1:0]      shadow_q [ROWS][COLS];
  logic [DATA_WIDTH-1:0]      active_q [ROWS][COLS];
  logic [ROWS*DATA_WIDTH-1:0] in_q;
  logic [LAT-1:0]             valid_q;
  logic [COLS*ACC_WIDTH-1:0]  result_data_q, result_data_d;
  logic                       result_valid_q;

  logic [DATA_WIDTH-1:0] a_w  [ROWS][COLS+1];
  logic [ACC_WIDTH-1:0]  p_w  [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  dsk_s [COLS];

  assign stall_s     = result_valid_q && !bus.result_ready;
  assign res_hs_s    = result_valid_q && bus.result_ready;
  assign act_ready_s = (state_q == RUN) && !stall_s && (acc_cnt_q < m_rows_q);
  assign accept_s    = bus.act_valid && act_ready_s;

  // Next-state, job configuration latch and acceptance/result counters
  always_comb begin
    state_d     = state_q;
    m_rows_d    = m_rows_q;
    sgn_d       = sgn_q;
    acc_cnt_d   = acc_cnt_q;
    res_cnt_d   = res_hs_s ? res_cnt_q + 16'd1 : res_cnt_q;
    start_acc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_acc_s = 1'b1;
          m_rows_d    = bus.cfg_m_rows;
          sgn_d       = bus.cfg_signed;
          acc_cnt_d   = 16'd0;
          res_cnt_d   = 16'd0;
          state_d     = (bus.cfg_m_rows == 16'd0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          acc_cnt_d = acc_cnt_q + 16'd1;
          state_d   = (acc_cnt_q + 16'd1 == m_rows_q) ? DRAIN : RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (res_hs_s && (res_cnt_q + 16'd1 == m_rows_q)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_rows_q  <= 16'd0;
      sgn_q     <= 1'b0;
      acc_cnt_q <= 16'd0;
      res_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      m_rows_q  <= m_rows_d;
      sgn_q     <= sgn_d;
      acc_cnt_q <= acc_cnt_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  // Shadow bank takes loads any time; start snapshots the pre-edge shadow into active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROWS; k++) begin
        for (int n = 0; n < COLS; n++) begin
          shadow_q[k][n] <= '0;
          active_q[k][n] <= '0;
        end
      end
    end else begin
      if (bus.weight_load_en && (32'(bus.weight_load_col) < COLS_U)) begin
        for (int k = 0; k < ROWS; k++) begin
          shadow_q[k][bus.weight_load_col] <= bus.weight_load_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (start_acc_s) begin
        active_q <= shadow_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= '0;
      valid_q <= '0;
    end else if (!stall_s) begin
      in_q    <= accept_s ? bus.act_data : '0;
      valid_q <= {valid_q[LAT-2:0], accept_s};
    end
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_skew
    if (k == 0) begin : g_direct
      assign a_w[k][0] = in_q[DATA_WIDTH-1:0];
    end else begin : g_sr
      logic [DATA_WIDTH-1:0] sr_q [k];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) sr_q[i] <= '0;
        end else if (!stall_s) begin
          sr_q[0] <= in_q[k*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < k; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign a_w[k][0] = sr_q[k-1];
    end
  end

  for (genvar n = 0; n < COLS; n++) begin : g_top
    assign p_w[0][n] = '0;
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_row
    for (genvar n = 0; n < COLS; n++) begin : g_col
      systolic_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (stall_s),
        .sgn_i  (sgn_q),
        .a_i    (a_w[k][n]),
        .w_i    (active_q[k][n]),
        .psum_i (p_w[k][n]),
        .a_o    (a_w[k][n+1]),
        .psum_o (p_w[k+1][n])
      );
    end
  end

  logic [ROWS*DATA_WIDTH-1:0] unused_act_s;
  for (genvar k = 0; k < ROWS; k++) begin : g_act_sink
    assign unused_act_s[k*DATA_WIDTH +: DATA_WIDTH] = a_w[k][COLS];
  end

  // Column n leaves the grid n cycles late; the deskew realigns all columns
  for (genvar n = 0; n < COLS; n++) begin : g_deskew
    localparam int D = COLS - 1 - n;
    if (D == 0) begin : g_direct
      assign dsk_s[n] = p_w[ROWS][n];
    end else begin : g_sr
      logic [ACC_WIDTH-1:0] dq_q [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) dq_q[i] <= '0;
        end else if (!stall_s) begin
          dq_q[0] <= p_w[ROWS][n];
          for (int i = 1; i < D; i++) dq_q[i] <= dq_q[i-1];
        end
      end
      assign dsk_s[n] = dq_q[D-1];
    end
  end

  always_comb begin
    result_data_d = '0;
    for (int n = 0; n < COLS; n++) result_data_d[n*ACC_WIDTH +: ACC_WIDTH] = dsk_s[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
    end else if (!stall_s) begin
      result_valid_q <= valid_q[LAT-1];
      result_data_q  <= result_data_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.act_ready    = act_ready_s;
  assign bus.result_valid = result_valid_q;
  assign bus.result_data  = result_data_q;
endmodule

// File: tb/tb_systolic_array_db.sv
// Randomised and directed bench for systolic_array_db: a negedge monitor keeps
// a matrix-level reference model and a scoreboard of expected result rows.
module tb_systolic_array_db;
  localparam int ROWS = 4, COLS = 4, DW = 8, AW = 32, LAT = ROWS + COLS;
  typedef logic [ROWS*DW-1:0] avec_t;
  typedef logic [COLS*AW-1:0] rvec_t;
  typedef struct { rvec_t data; int acc_edge; int acc_stall; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  systolic_array_db_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) sa_if ();
  systolic_array_db #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(sa_if)
  );
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, stall_cnt = 0, ready_mode = 0, hold_cnt = 0;
  exp_t  exp_q[$];
  rvec_t dir_q[$];
  avec_t a_rows[$];
  logic [DW-1:0] w_sh [ROWS][COLS];
  logic [DW-1:0] w_act[ROWS][COLS];
  logic [DW-1:0] mat  [ROWS][COLS];
  bit sgn_m;
  int m_exp, res_seen;

  function automatic void check(string name, logic [COLS*AW-1:0] got, logic [COLS*AW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // C[n] = sum_k A[k]*B[k][n] with plain integer arithmetic, wrapped to AW bits
  function automatic rvec_t ref_row(avec_t a);
    rvec_t r;
    for (int n = 0; n < COLS; n++) begin
      longint s = 0;
      for (int k = 0; k < ROWS; k++) begin
        longint av = sgn_m ? longint'($signed(a[k*DW +: DW])) : longint'(a[k*DW +: DW]);
        longint bv = sgn_m ? longint'($signed(w_act[k][n])) : longint'(w_act[k][n]);
        s += av * bv;
      end
      r[n*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  function automatic avec_t pack_a(int a0, int a1, int a2, int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction
  function automatic rvec_t pack_r(int c0, int c1, int c2, int c3);
    return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
  endfunction
  function automatic rvec_t scale_row(avec_t a, int s);
    rvec_t r;
    for (int n = 0; n < COLS; n++) r[n*AW +: AW] = 32'(s * int'(a[n*DW +: DW]));
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Result consumer: 0 always ready, 1 random, 2 hold low 5 cycles on first result, 3 never
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: sa_if.result_ready = 1'b1;
      1: sa_if.result_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (sa_if.result_valid && hold_cnt < 5) begin
          sa_if.result_ready = 1'b0;
          hold_cnt++;
        end else begin
          sa_if.result_ready = (hold_cnt >= 5);
        end
      end
      3: sa_if.result_ready = 1'b0;
      default: sa_if.result_ready = 1'b1;
    endcase
    if (ready_mode != 2) hold_cnt = 0;
  end

  // Monitor / scoreboard: observes every handshake just before the edge it happens on
  initial begin
    bit done_exp, nd, prev_done, prev_stall, stall_now;
    rvec_t prev_data;
    exp_t e;
    done_exp = 0; prev_done = 0; prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); dir_q.delete();
        for (int k = 0; k < ROWS; k++)
          for (int n = 0; n < COLS; n++) begin w_sh[k][n] = '0; w_act[k][n] = '0; end
        done_exp = 0; prev_done = 0; prev_stall = 0; m_exp = 0; res_seen = 0;
      end else begin
        if (done_exp || sa_if.done) check("done_pulse", sa_if.done, done_exp);
        if (sa_if.done) check("busy_with_done", sa_if.busy, 1);
        if (prev_done) check("busy_after_done", sa_if.busy, 0);
        if (prev_stall) begin
          check("stall_hold_data", sa_if.result_data, prev_data);
          check("stall_hold_valid", sa_if.result_valid, 1);
        end
        stall_now = sa_if.result_valid && !sa_if.result_ready;
        if (stall_now) begin
          check("act_ready_in_stall", sa_if.act_ready, 0);
          stall_cnt++;
        end
        if (!sa_if.busy) check("act_ready_idle", sa_if.act_ready, 0);
        nd = 0;
        if (sa_if.start && !sa_if.busy) begin
          w_act = w_sh;
          sgn_m = sa_if.cfg_signed;
          m_exp = int'(sa_if.cfg_m_rows);
          res_seen = 0;
          if (m_exp == 0) nd = 1;
        end
        if (sa_if.weight_load_en && int'(sa_if.weight_load_col) < COLS)
          for (int k = 0; k < ROWS; k++)
            w_sh[k][sa_if.weight_load_col] = sa_if.weight_load_data[k*DW +: DW];
        if (sa_if.act_valid && sa_if.act_ready)
          exp_q.push_back('{data: ref_row(sa_if.act_data), acc_edge: cyc + 1, acc_stall: stall_cnt});
        if (sa_if.result_valid) check("result_queued", exp_q.size() > 0, 1);
        if (sa_if.result_valid && sa_if.result_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("result_row", sa_if.result_data, e.data);
          check("latency", (cyc + 1) - e.acc_edge - (stall_cnt - e.acc_stall), LAT + 1);
          if (dir_q.size() > 0) check("directed_row", sa_if.result_data, dir_q.pop_front());
          res_seen++;
          if (res_seen == m_exp) nd = 1;
        end
        prev_done = sa_if.done; prev_stall = stall_now; prev_data = sa_if.result_data;
        done_exp = nd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_col(int col, avec_t d);
    sa_if.weight_load_en = 1'b1;
    sa_if.weight_load_col = 2'(col);
    sa_if.weight_load_data = d;
    tick();
    sa_if.weight_load_en = 1'b0;
  endtask

  task automatic load_mat();
    for (int n = 0; n < COLS; n++) begin
      avec_t d;
      for (int k = 0; k < ROWS; k++) d[k*DW +: DW] = mat[k][n];
      load_col(n, d);
    end
  endtask

  task automatic set_mat(int mode, int s);
    for (int k = 0; k < ROWS; k++)
      for (int n = 0; n < COLS; n++)
        mat[k][n] = (mode == 0) ? ((k == n) ? 8'(s) : 8'd0) : 8'($urandom);
  endtask

  task automatic start_job(int m, bit sgn);
    sa_if.start = 1'b1;
    sa_if.cfg_m_rows = 16'(m);
    sa_if.cfg_signed = sgn;
    tick();
    sa_if.start = 1'b0;
  endtask

  task automatic push_act(avec_t v);
    bit ok = 0;
    sa_if.act_valid = 1'b1;
    sa_if.act_data = v;
    for (int g = 0; g < 500 && !ok; g++) begin
      @(negedge clk);
      if (sa_if.act_ready) ok = 1;
    end
    @(posedge clk);
    #1;
    sa_if.act_valid = 1'b0;
    check("act_accept_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      if (!sa_if.busy) fin = 1;
    end
    check("job_completes", fin, 1);
    tick();
  endtask

  task automatic run_job(int m, bit sgn, int gap, bit mid);
    start_job(m, sgn);
    for (int i = 0; i < m; i++) begin
      push_act(a_rows[i]);
      if (mid && i == 0) load_mat();
      if (gap > 0 && $urandom_range(0, 99) < gap) tick();
    end
    wait_idle();
    a_rows.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sa_if.start = 0; sa_if.cfg_m_rows = '0; sa_if.cfg_signed = 0;
    sa_if.weight_load_en = 0; sa_if.weight_load_col = '0; sa_if.weight_load_data = '0;
    sa_if.act_valid = 0; sa_if.act_data = '0; sa_if.result_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", sa_if.busy, 0);
    check("rst_done", sa_if.done, 0);
    check("rst_act_ready", sa_if.act_ready, 0);
    check("rst_result_valid", sa_if.result_valid, 0);
    check("rst_result_data", sa_if.result_data, 0);
    rst_n = 1'b1;
    tick();

    // B = [[1,2],[2,3]] zero-padded, two back-to-back rows
    set_mat(0, 0);
    mat[0][0] = 8'd1; mat[0][1] = 8'd2; mat[1][0] = 8'd2; mat[1][1] = 8'd3;
    load_mat();
    a_rows = '{pack_a(1, 1, 0, 0), pack_a(2, 2, 0, 0)};
    dir_q.push_back(pack_r(3, 5, 0, 0));
    dir_q.push_back(pack_r(6, 10, 0, 0));
    run_job(2, 0, 0, 0);

    // Identity weights, A = 1..16 row-major
    set_mat(0, 1);
    load_mat();
    for (int i = 0; i < 4; i++) begin
      a_rows.push_back(pack_a(4*i+1, 4*i+2, 4*i+3, 4*i+4));
      dir_q.push_back(pack_r(4*i+1, 4*i+2, 4*i+3, 4*i+4));
    end
    run_job(4, 0, 0, 0);

    // Signed versus unsigned interpretation of 0xFF * 0x02
    set_mat(0, 0);
    mat[0][0] = 8'hFF;
    load_mat();
    a_rows.push_back(pack_a(2, 0, 0, 0));
    dir_q.push_back(pack_r(-2, 0, 0, 0));
    run_job(1, 1, 0, 0);
    a_rows.push_back(pack_a(2, 0, 0, 0));
    dir_q.push_back(pack_r(510, 0, 0, 0));
    run_job(1, 0, 0, 0);

    // First result held off for 5 cycles
    ready_mode = 2;
    set_mat(1, 0);
    load_mat();
    for (int i = 0; i < 4; i++) a_rows.push_back(avec_t'($urandom));
    run_job(4, 0, 0, 0);
    ready_mode = 0;

    // Shadow reload during a job only affects the next job
    set_mat(0, 2);
    load_mat();
    set_mat(0, 1);
    for (int i = 0; i < 4; i++) begin
      a_rows.push_back(avec_t'($urandom));
      dir_q.push_back(scale_row(a_rows[i], 2));
    end
    run_job(4, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      a_rows.push_back(avec_t'($urandom));
      dir_q.push_back(scale_row(a_rows[i], 1));
    end
    run_job(4, 0, 0, 0);

    // Empty job
    run_job(0, 0, 0, 0);

    // Randomised jobs with backpressure, bubbles and mid-job shadow loads
    ready_mode = 1;
    for (int j = 0; j < 6; j++) begin
      int m;
      set_mat(1, 0);
      load_mat();
      set_mat(1, 0);
      m = $urandom_range(1, 10);
      for (int i = 0; i < m; i++) a_rows.push_back(avec_t'($urandom));
      run_job(m, 1'($urandom_range(0, 1)), 30, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while draining
    ready_mode = 3;
    set_mat(1, 0);
    load_mat();
    start_job(4, 0);
    for (int i = 0; i < 4; i++) push_act(avec_t'($urandom));
    repeat (3) tick();
    check("busy_before_reset", sa_if.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", sa_if.busy, 0);
    check("arst_done", sa_if.done, 0);
    check("arst_act_ready", sa_if.act_ready, 0);
    check("arst_result_valid", sa_if.result_valid, 0);
    check("arst_result_data", sa_if.result_data, 0);
    tick();
    rst_n = 1'b1;
    ready_mode = 0;
    tick();

    // Recovery job after reset
    set_mat(1, 0);
    load_mat();
    for (int i = 0; i < 3; i++) a_rows.push_back(avec_t'($urandom));
    run_job(3, 1, 0, 0);
    repeat (3) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
